// File: rtl/pkg_dift.sv
// Shared constants and types for the DIFT tag memory responder.
// Holds the tag width, the init/serve FSM states and the response opcode values.
package pkg_dift;

  localparam int unsigned TAG_BITS_NUM = 4;
  localparam int unsigned DATA_BITS    = 32;
  localparam int unsigned WORD_BITS    = DATA_BITS + TAG_BITS_NUM;

  typedef enum logic {
    INIT  = 1'b0,
    SERVE = 1'b1
  } dift_state_e;

  localparam logic OPC_OK  = 1'b0;
  localparam logic OPC_ERR = 1'b1;

endpackage

// File: rtl/XBAR_TCDM_BUS_36.sv
// TCDM-style request/response bus with 36-bit data (32 data bits plus 4 tag bits).
// The responder has no ready input: every response is accepted by the requester.
interface XBAR_TCDM_BUS_36;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [35:0] wdata;
  logic        gnt;
  logic        r_valid;
  logic        r_opc;
  logic [35:0] r_rdata;

  modport Master (
    output req, add, wen, be, wdata,
    input  gnt, r_valid, r_opc, r_rdata
  );

  modport Slave (
    input  req, add, wen, be, wdata,
    output gnt, r_valid, r_opc, r_rdata
  );
endinterface

// File: rtl/dift_resp_delay.sv
// Fixed-latency response pipeline: valid, opcode and read data move one stage per cycle.
// Inputs are expected to be zero whenever vld_i is low, so idle outputs stay zero.
module dift_resp_delay #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DW      = 36
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          vld_i,
  input  logic          opc_i,
  input  logic [DW-1:0] dat_i,
  output logic          vld_o,
  output logic          opc_o,
  output logic [DW-1:0] dat_o
);

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] opc_q;
  logic [DW-1:0]      dat_q [LATENCY];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      opc_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      opc_q[0] <= opc_i;
      dat_q[0] <= dat_i;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        opc_q[i] <= opc_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[LATENCY-1];
  assign opc_o = opc_q[LATENCY-1];
  assign dat_o = dat_q[LATENCY-1];

endmodule

// File: rtl/dift_tag_mem_responder.sv
// TCDM responder backing 32-bit data plus one tag bit per byte, answering every grant after RESP_LATENCY cycles.
// After reset or tag_init_i, the tag array is swept to INIT_TAG and requests are refused until the sweep ends.
module dift_tag_mem_responder
  import pkg_dift::*;
#(
  parameter int unsigned              MEM_WORDS    = 1024,
  parameter int unsigned              RESP_LATENCY = 1,
  parameter logic [TAG_BITS_NUM-1:0]  INIT_TAG     = 4'b0000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  XBAR_TCDM_BUS_36.Slave slave,
  input  logic           tag_init_i,
  output logic           init_busy_o
);

  localparam int unsigned     AW         = $clog2(MEM_WORDS);
  localparam logic [AW-1:0]   LAST_IDX   = AW'(MEM_WORDS - 1);
  localparam logic [31:0]     ADDR_LIMIT = 32'(4 * MEM_WORDS);

  dift_state_e                state_q;
  logic [AW-1:0]              cnt_q;
  logic [DATA_BITS-1:0]       data_mem [MEM_WORDS];
  logic [TAG_BITS_NUM-1:0]    tag_mem  [MEM_WORDS];

  logic                       gnt;
  logic                       oor;
  logic                       wr_en;
  logic [AW-1:0]              idx;
  logic [WORD_BITS-1:0]       rd_word;
  logic                       resp_opc;
  logic [WORD_BITS-1:0]       resp_dat;
  logic                       unused_add_lsb;

  assign idx            = slave.add[AW+1:2];
  assign unused_add_lsb = ^slave.add[1:0];
  assign oor            = (slave.add >= ADDR_LIMIT);
  assign gnt            = slave.req & (state_q == SERVE);
  assign wr_en          = gnt & ~slave.wen & ~oor;
  assign slave.gnt      = gnt;
  assign init_busy_o    = (state_q == INIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        INIT: begin
          if (tag_init_i) begin
            cnt_q <= '0;
          end else if (cnt_q == LAST_IDX) begin
            state_q <= SERVE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        SERVE: begin
          if (tag_init_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  // Arrays are not reset; the sweep rewrites tags and no grant can collide with it.
  always_ff @(posedge clk_i) begin
    if (state_q == INIT) begin
      tag_mem[cnt_q] <= INIT_TAG;
    end else if (wr_en) begin
      for (int i = 0; i < TAG_BITS_NUM; i++) begin
        if (slave.be[i]) begin
          data_mem[idx][8*i +: 8] <= slave.wdata[8*i +: 8];
          tag_mem[idx][i]         <= slave.wdata[DATA_BITS + i];
        end
      end
    end
  end

  // Read data is captured at grant time, so a later sweep cannot alter it.
  assign rd_word  = {tag_mem[idx], data_mem[idx]};
  assign resp_opc = gnt & oor;
  assign resp_dat = (gnt & slave.wen & ~oor) ? rd_word : '0;

  dift_resp_delay #(
    .LATENCY (RESP_LATENCY),
    .DW      (WORD_BITS)
  ) u_resp_delay (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .vld_i (gnt),
    .opc_i (resp_opc),
    .dat_i (resp_dat),
    .vld_o (slave.r_valid),
    .opc_o (slave.r_opc),
    .dat_o (slave.r_rdata)
  );

endmodule

// File: tb/tb_dift_tag_mem_responder.sv
// Bench for dift_tag_mem_responder: directed scenarios with literal expectations plus a random phase,
// all outputs compared every cycle against a word-level memory model with a due-cycle response queue.
module tb_dift_tag_mem_responder;

  localparam int         MW   = 16;
  localparam int         LAT  = 3;
  localparam logic [3:0] ITAG = 4'b0000;

  logic clk_i      = 1'b0;
  logic rst_i      = 1'b1;
  logic tag_init_i = 1'b0;
  logic init_busy_o;

  XBAR_TCDM_BUS_36 bus();

  dift_tag_mem_responder #(
    .MEM_WORDS    (MW),
    .RESP_LATENCY (LAT),
    .INIT_TAG     (ITAG)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .slave       (bus),
    .tag_init_i  (tag_init_i),
    .init_busy_o (init_busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: word contents, known-byte mask, remaining sweep cycles, pending responses.
  typedef struct {
    int          due;
    logic        opc;
    logic [35:0] dat;
    logic [35:0] msk;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] m_data  [MW];
  logic [3:0]  m_tag   [MW];
  logic [3:0]  m_known [MW];
  int          m_busy = MW;
  logic [36:0] obs[int];

  always @(negedge clk_i) begin : cmp
    logic  exp_gnt;
    logic  oor;
    int    w;
    resp_t r;
    if (rst_i) begin
      exp_q.delete();
      m_busy = MW;
      check("rst_gnt",     64'(bus.gnt),     64'd0);
      check("rst_rvalid",  64'(bus.r_valid), 64'd0);
      check("rst_ropc",    64'(bus.r_opc),   64'd0);
      check("rst_rdata",   64'(bus.r_rdata), 64'd0);
      check("rst_busy",    64'(init_busy_o), 64'd1);
    end else begin
      exp_gnt = bus.req && (m_busy == 0);
      check("gnt",  64'(bus.gnt),     64'(exp_gnt));
      check("busy", 64'(init_busy_o), 64'(m_busy != 0));
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        r = exp_q.pop_front();
        check("rvalid", 64'(bus.r_valid), 64'd1);
        check("ropc",   64'(bus.r_opc),   64'(r.opc));
        check("rdata",  64'(bus.r_rdata & r.msk), 64'(r.dat & r.msk));
      end else begin
        check("rvalid_idle", 64'(bus.r_valid), 64'd0);
        check("ropc_idle",   64'(bus.r_opc),   64'd0);
        check("rdata_idle",  64'(bus.r_rdata), 64'd0);
      end
      if (bus.r_valid) obs[cyc] = {bus.r_opc, bus.r_rdata};
      if (exp_gnt) begin
        oor   = (bus.add >= 32'(4 * MW));
        w     = int'(bus.add / 4) % MW;
        r.due = cyc + LAT;
        r.opc = oor;
        r.dat = '0;
        r.msk = '1;
        if (!oor && bus.wen) begin
          r.dat = {m_tag[w], m_data[w]};
          r.msk = {4'hF, {8{m_known[w][3]}}, {8{m_known[w][2]}}, {8{m_known[w][1]}}, {8{m_known[w][0]}}};
        end
        if (!oor && !bus.wen) begin
          for (int i = 0; i < 4; i++) begin
            if (bus.be[i]) begin
              m_data[w][8*i +: 8] = bus.wdata[8*i +: 8];
              m_tag[w][i]         = bus.wdata[32+i];
              m_known[w][i]       = 1'b1;
            end
          end
        end
        exp_q.push_back(r);
      end
      if (tag_init_i) begin
        m_busy = MW;
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) for (int i = 0; i < MW; i++) m_tag[i] = ITAG;
      end
    end
  end

  function automatic logic [35:0] fill_word(input int w);
    return {4'(w) ^ 4'h9, 32'hC0DE_0000 | 32'(w)};
  endfunction

  task automatic issue(input logic wen, input logic [31:0] add, input logic [3:0] be,
                       input logic [35:0] wd, output int g);
    bus.req   = 1'b1;
    bus.wen   = wen;
    bus.add   = add;
    bus.be    = be;
    bus.wdata = wd;
    g         = cyc;
    @(posedge clk_i); #1;
    bus.req   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic expect_resp(input string name, input int g, input logic opc,
                             input logic [35:0] dat, input logic [35:0] msk);
    int t;
    t = g + LAT;
    for (int k = 0; k < 50 && cyc <= t; k++) begin @(posedge clk_i); #1; end
    check({name, "_rvalid"}, 64'(obs.exists(t)), 64'd1);
    if (obs.exists(t)) begin
      check({name, "_opc"},   64'(obs[t][36]), 64'(opc));
      check({name, "_rdata"}, 64'(obs[t][35:0] & msk), 64'(dat & msk));
    end
  endtask

  initial begin : stim
    int          g, g1, g2, busy_n, gnt_bad, vld_n;
    int          gs [8];
    logic [35:0] exp_w [MW];
    for (int i = 0; i < MW; i++) m_known[i] = 4'h0;
    bus.req = 1'b0; bus.wen = 1'b1; bus.add = '0; bus.be = '0; bus.wdata = '0;
    idle(3);
    check("rst_hold_busy",   64'(init_busy_o),   64'd1);
    check("rst_hold_rvalid", 64'(bus.r_valid),   64'd0);

    // Reset release with a pending read: no grant for exactly MEM_WORDS sweep cycles.
    bus.req = 1'b1; bus.wen = 1'b1; bus.add = 32'h0; rst_i = 1'b0;
    busy_n = 0; gnt_bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (!init_busy_o) break;
      busy_n++;
      if (bus.gnt) gnt_bad++;
    end
    @(posedge clk_i); #1; bus.req = 1'b0;
    check("init_cycles",  64'(busy_n),  64'd16);
    check("init_no_gnt",  64'(gnt_bad), 64'd0);
    issue(1'b1, 32'hC, 4'h0, '0, g);
    expect_resp("init_tag_w3", g, 1'b0, 36'h0, 36'hF_0000_0000);

    for (int w = 0; w < MW; w++) begin
      exp_w[w] = fill_word(w);
      issue(1'b0, 32'(w * 4), 4'hF, exp_w[w], g);
    end

    // Byte-enable merge, read in the cycle right after the write.
    issue(1'b0, 32'h8, 4'hF,    36'h0_11223344, g);
    issue(1'b0, 32'h8, 4'b0101, 36'hF_AABBCCDD, g);
    issue(1'b1, 32'h8, 4'h0,    '0, g);
    expect_resp("be_merge", g, 1'b0, 36'h5_11BB33DD, '1);
    exp_w[2] = 36'h5_11BB33DD;

    for (int k = 0; k < 8; k++) issue(1'b1, 32'((8 + k) * 4), 4'h0, '0, gs[k]);
    idle(LAT + 2);
    check("b2b_contig", 64'(gs[7] - gs[0]), 64'd7);
    for (int k = 0; k < 8; k++)
      expect_resp($sformatf("b2b_rd%0d", k), gs[k], 1'b0, exp_w[8 + k], '1);
    check("b2b_no_early", 64'(obs.exists(gs[0] + LAT - 1)), 64'd0);
    check("b2b_no_late",  64'(obs.exists(gs[0] + LAT + 8)), 64'd0);

    issue(1'b1, 32'(4 * MW), 4'h0, '0, g);
    expect_resp("oor_rd", g, 1'b1, 36'h0, '1);
    issue(1'b0, 32'(4 * MW), 4'hF, '1, g);
    expect_resp("oor_wr", g, 1'b1, 36'h0, '1);
    issue(1'b0, 32'hFFFF_FFFC, 4'hF, '1, g);
    issue(1'b1, 32'h0, 4'h0, '0, g);
    expect_resp("oor_no_alias", g, 1'b0, exp_w[0], '1);

    // Re-init sweep with two reads still in flight.
    exp_w[4] = 36'hF_DEADBEEF;
    issue(1'b0, 32'h10, 4'hF, exp_w[4], g);
    expect_resp("wr_resp_zero", g, 1'b0, 36'h0, '1);
    issue(1'b1, 32'h10, 4'h0, '0, g1);
    issue(1'b1, 32'h14, 4'h0, '0, g2);
    tag_init_i = 1'b1;
    @(posedge clk_i); #1;
    tag_init_i = 1'b0;
    bus.req = 1'b1; bus.wen = 1'b1; bus.add = 32'h0;
    busy_n = 0; gnt_bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (!init_busy_o) break;
      busy_n++;
      if (bus.gnt) gnt_bad++;
    end
    @(posedge clk_i); #1; bus.req = 1'b0;
    check("sweep_cycles", 64'(busy_n),  64'd16);
    check("sweep_no_gnt", 64'(gnt_bad), 64'd0);
    expect_resp("inflight_a", g1, 1'b0, exp_w[4], '1);
    expect_resp("inflight_b", g2, 1'b0, exp_w[5], '1);
    for (int w = 0; w < MW; w++) begin
      issue(1'b1, 32'(w * 4), 4'h0, '0, g);
      expect_resp($sformatf("post_sweep_w%0d", w), g, 1'b0, {ITAG, exp_w[w][31:0]}, '1);
    end

    // Reset while a read response is in flight.
    issue(1'b1, 32'h4, 4'h0, '0, g);
    rst_i = 1'b1;
    vld_n = 0; busy_n = 0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk_i);
      if (bus.r_valid) vld_n++;
      if (init_busy_o && !rst_i) busy_n++;
      if (k == 1) begin @(posedge clk_i); #1; rst_i = 1'b0; end
    end
    check("rst_flush_no_rvalid", 64'(vld_n), 64'd0);
    check("rst_flush_no_obs",    64'(obs.exists(g + LAT)), 64'd0);
    check("rst_reinit_cycles",   64'(busy_n), 64'd16);

    for (int k = 0; k < 400; k++) begin
      bus.req    = ($urandom_range(0, 3) != 0);
      bus.wen    = 1'($urandom_range(0, 1));
      bus.add    = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom_range(0, 79));
      bus.be     = 4'($urandom);
      bus.wdata  = {4'($urandom), $urandom};
      tag_init_i = ($urandom_range(0, 79) == 0);
      @(posedge clk_i); #1;
    end
    bus.req = 1'b0; tag_init_i = 1'b0;
    idle(LAT + 4);
    check("resp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
